// File: rtl/input_buffer_pkg.sv
// Types and helpers shared by the CUT I/O buffers and their sequencing controller.
package input_buffer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } buf_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/input_buffer.sv
// Serial-to-parallel word buffer: gathers DEPTH words (first word in slot 0) into one
// parallel frame and holds it until the consumer acknowledges it.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shift,
  input  logic [DATA_WIDTH-1:0]       input_data,
  input  logic                        consume,
  output logic                        ready,
  output logic                        full,
  output logic [CNT_W-1:0]            count,
  output logic                        overflow,
  output logic [DEPTH*DATA_WIDTH-1:0] output_data
);

  buf_state_t                            state_reg;
  logic [CNT_W-1:0]                      count_reg;
  logic                                  overflow_reg;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      buf_reg;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      buf_next;

  // Shifted image of the storage: every slot takes its upper neighbour and the newest
  // word enters at the top, so after DEPTH words the oldest one reaches slot 0.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
    if (gi == DEPTH - 1) begin : gen_top
      assign buf_next[gi] = input_data;
    end else begin : gen_mid
      assign buf_next[gi] = buf_reg[gi + 1];
    end
    assign output_data[gi*DATA_WIDTH +: DATA_WIDTH] = buf_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state_reg    <= FILL;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      buf_reg      <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (shift) begin
            buf_reg <= buf_next;
            if (count_reg == CNT_W'(DEPTH - 1)) begin
              state_reg <= FULL;
              count_reg <= CNT_W'(DEPTH);
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        FULL: begin
          if (consume) begin
            // A word arriving with the acknowledge starts the next frame immediately.
            state_reg <= FILL;
            if (shift) begin
              buf_reg   <= buf_next;
              count_reg <= CNT_W'(1);
            end else begin
              count_reg <= '0;
            end
          end else if (shift) begin
            overflow_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= FILL;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign ready    = (state_reg == FILL);
  assign full     = (state_reg == FULL);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_input_buffer.sv
// Randomized and directed bench for input_buffer against a queue-based frame model,
// plus a small DEPTH=4 instance for the gapped-stream case.
module tb_input_buffer;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int OW = DW * D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          shift = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic          consume = 1'b0;
  logic          ready;
  logic          full;
  logic [4:0]    count;
  logic          overflow;
  logic [OW-1:0] output_data;

  logic          g_shift = 1'b0;
  logic [7:0]    g_data = '0;
  logic          g_ready;
  logic          g_full;
  logic [2:0]    g_count;
  logic          g_overflow;
  logic [31:0]   g_out;

  int checks = 0;
  int errors = 0;

  // Model: a window of the last D accepted words (oldest at slot 0) plus frame status.
  logic [DW-1:0] hist[$];
  int            m_count;
  bit            m_full;
  bit            m_ovf;

  always #5 clk = ~clk;

  input_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear), .shift(shift), .input_data(input_data),
    .consume(consume), .ready(ready), .full(full), .count(count),
    .overflow(overflow), .output_data(output_data)
  );

  input_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .clear(1'b0), .shift(g_shift), .input_data(g_data),
    .consume(1'b0), .ready(g_ready), .full(g_full), .count(g_count),
    .overflow(g_overflow), .output_data(g_out)
  );

  task automatic check_value(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back('0);
    m_count = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    hist.push_back(d);
    void'(hist.pop_front());
  endtask

  task automatic model_update(input logic r, c, s, cons, input logic [DW-1:0] d);
    if (!r || c) begin
      model_reset();
    end else if (!m_full) begin
      if (s) begin
        model_accept(d);
        m_count++;
        if (m_count == D) m_full = 1'b1;
      end
    end else if (cons) begin
      m_full = 1'b0;
      if (s) begin
        model_accept(d);
        m_count = 1;
      end else begin
        m_count = 0;
      end
    end else if (s) begin
      m_ovf = 1'b1;
    end
  endtask

  function automatic logic [OW-1:0] model_frame();
    logic [OW-1:0] f;
    f = '0;
    for (int i = 0; i < D; i++) f[i*DW +: DW] = hist[i];
    return f;
  endfunction

  task automatic check_all();
    check_value("ready", OW'(ready), OW'(!m_full));
    check_value("full", OW'(full), OW'(m_full));
    check_value("count", OW'(count), OW'(m_count));
    check_value("overflow", OW'(overflow), OW'(m_ovf));
    check_value("output_data", output_data, model_frame());
  endtask

  task automatic step(input logic r, c, s, cons, input logic [DW-1:0] d);
    rst = r; clear = c; shift = s; consume = cons; input_data = d;
    @(posedge clk);
    model_update(r, c, s, cons, d);
    #1;
    check_all();
    $display("txn rst=%0b clr=%0b shift=%0b cons=%0b data=%08h -> count=%0d full=%0b ovf=%0b",
             r, c, s, cons, d, count, full, overflow);
  endtask

  initial begin
    model_reset();

    // Reset held with shift active and random data.
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, $urandom);

    // In-order fill.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000 + i);
    check_value("fill_slot0", OW'(output_data[0 +: DW]), OW'(32'h1000));
    check_value("fill_slot15", OW'(output_data[15*DW +: DW]), OW'(32'h100F));

    // Overflow while full.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    check_value("ovf_flag", OW'(overflow), OW'(1'b1));

    // Consume and shift together, then complete the frame.
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5);
    check_value("cs_count", OW'(count), OW'(1));
    for (int i = 0; i < D - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    check_value("cs_slot0", OW'(output_data[0 +: DW]), OW'(32'hA5A5A5A5));
    check_value("ovf_sticky", OW'(overflow), OW'(1'b1));

    // Clear mid-frame, then a fresh frame.
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_value("clr_data", output_data, '0);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000 + i);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(63) != 0, $urandom_range(31) == 0,
           $urandom_range(3) != 0, $urandom_range(3) == 0, $urandom);
    end

    // Gapped stream on the DEPTH=4 instance (main instance held idle).
    rst = 1'b1; clear = 1'b0; shift = 1'b0; consume = 1'b0;
    g_shift = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(3);
      for (int k = 0; k < gap; k++) begin
        g_shift = 1'b0;
        @(posedge clk); #1;
        check_value("gap_not_full", OW'(g_full), OW'(1'b0));
      end
      g_shift = 1'b1;
      g_data  = 8'(8'h11 * (i + 1));
      @(posedge clk); #1;
      g_shift = 1'b0;
      check_value("gap_full", OW'(g_full), OW'(i == 3));
      $display("txn gapped word=%02h -> count=%0d full=%0b", g_data, g_count, g_full);
    end
    check_value("gap_data", OW'(g_out), OW'(32'h44332211));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
